// File: rtl/comb_loop_pkg.sv
`default_nettype none
// ============================================================================
// Package  : comb_loop_pkg
// Brief    : Shared definitions for the comb-loop checker: the run-control
//            state encoding and the saturating-increment helper used by the
//            result counters.
// Contents : state_t    - IDLE / RUN / REPORT, explicit 2-bit encoding
//            c_SAT_W    - widest counter the helper supports
//            sat_inc()  - increment that sticks at 2^width-1
// Revision : 1.0 - initial release
// ============================================================================
package comb_loop_pkg;

  // Widest result counter the saturating helper can handle.
  localparam int unsigned c_SAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // Returns value+1, but never beyond the all-ones value of a counter that is
  // 'width' bits wide. Callers size-cast the result back to their own width,
  // so the counter holds at its maximum instead of wrapping to zero.
  function automatic logic [c_SAT_W-1:0] sat_inc(input logic [c_SAT_W-1:0] value,
                                                 input int unsigned        width);
    logic [c_SAT_W-1:0] max_val;
    if (width >= c_SAT_W) begin
      max_val = '1;
    end else begin
      max_val = (32'd1 << width) - 32'd1;
    end
    if (value >= max_val) begin
      return max_val;
    end
    return value + 32'd1;
  endfunction

endpackage : comb_loop_pkg
`default_nettype wire

// File: rtl/comb_loop_checker_if.sv
`default_nettype none
// ============================================================================
// Interface : comb_loop_checker_if
// Brief     : Bundles the run request, the three monitored loop outputs and
//             the result handshake of the comb-loop checker.
// Signals   : start              - one-cycle run request
//             a_in, b_in, c_in   - loop outputs, asynchronous to the clock
//             busy               - run in progress
//             res_valid/ready    - result handshake
//             err_cnt, tog_cnt   - result counters (CNT_W bits)
//             pass               - err_cnt == 0
// Modports  : master - the side driving stimulus and consuming results
//             slave  - the checker itself
// Revision  : 1.0 - initial release
// ============================================================================
interface comb_loop_checker_if #(
  parameter int CNT_W = 8
);

  logic             start;
  logic             a_in;
  logic             b_in;
  logic             c_in;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] tog_cnt;
  logic             pass;

  modport master (
    output start,
    output a_in,
    output b_in,
    output c_in,
    output res_ready,
    input  busy,
    input  res_valid,
    input  err_cnt,
    input  tog_cnt,
    input  pass
  );

  modport slave (
    input  start,
    input  a_in,
    input  b_in,
    input  c_in,
    input  res_ready,
    output busy,
    output res_valid,
    output err_cnt,
    output tog_cnt,
    output pass
  );

endinterface : comb_loop_checker_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for a single asynchronous bit.
// Ports    : clk   - destination clock
//            rst_n - asynchronous active-low reset, clears both flops
//            i_d   - asynchronous input
//            o_q   - synchronized output, two clock cycles of latency
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  // r_meta may go metastable; only r_sync is ever observed downstream.
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/comb_loop_checker.sv
`default_nettype none
// ============================================================================
// Module   : comb_loop_checker
// Brief    : Observes the three outputs (a, b, c) of an upstream
//            combinational loop for a fixed window of cycles. A consistent
//            loop has b == c and c != a. Every cycle that breaks this is
//            counted in err_cnt. Every change of c is counted in tog_cnt. The
//            result is then presented through a valid/ready handshake.
// Params   : WINDOW - checked cycles per run (1..65535)
//            CNT_W  - result counter width (1..32)
// Ports    : sys_clk   - clock, all state on the rising edge
//            sys_rst_n - asynchronous active-low reset
//            bus       - comb_loop_checker_if.slave:
//                        start, a_in/b_in/c_in, res_ready   (in)
//                        busy, res_valid, err_cnt, tog_cnt, pass (out)
// Revision : 1.0 - initial release
// ============================================================================
module comb_loop_checker
  import comb_loop_pkg::*;
#(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  comb_loop_checker_if.slave  bus
);

  // Wide enough to hold WINDOW itself, so the counter never overflows.
  localparam int                 c_WIN_W    = $clog2(WINDOW + 1);
  localparam logic [c_WIN_W-1:0] c_LAST_IDX = c_WIN_W'(WINDOW - 1);

  // --------------------------------------------------------------------------
  // Input synchronization
  // --------------------------------------------------------------------------
  logic w_a_s;
  logic w_b_s;
  logic w_c_s;

  sync_2ff u_sync_a (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .i_d   (bus.a_in),
    .o_q   (w_a_s)
  );

  sync_2ff u_sync_b (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .i_d   (bus.b_in),
    .o_q   (w_b_s)
  );

  sync_2ff u_sync_c (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .i_d   (bus.c_in),
    .o_q   (w_c_s)
  );

  // --------------------------------------------------------------------------
  // Previous value of synchronized c. It is tracked in every state, so the
  // first RUN cycle already compares against real history. Without it, a
  // stale value would be left over from the last run.
  // --------------------------------------------------------------------------
  logic r_c_prev;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_c_prev <= 1'b0;
    end else begin
      r_c_prev <= w_c_s;
    end
  end

  // --------------------------------------------------------------------------
  // Run-control FSM
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_start_run;
  logic               w_busy;
  logic               w_res_valid;
  logic [c_WIN_W-1:0] r_win_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // start is only looked at in IDLE. A start that coincides with the
  // REPORT->IDLE edge is therefore dropped, as is any start during a run.
  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    w_busy      = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_start_run = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_win_cnt == c_LAST_IDX) begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        w_res_valid = 1'b1;
        if (bus.res_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-cycle invariant checks on the synchronized loop outputs
  // --------------------------------------------------------------------------
  logic w_violation;
  logic w_toggle;

  assign w_violation = (w_b_s != w_c_s) || (w_c_s == w_a_s);
  assign w_toggle    = (w_c_s != r_c_prev);

  // --------------------------------------------------------------------------
  // Window and result counters. They are cleared on the start edge and only
  // advance in RUN. Outside RUN they hold, which keeps the reported values
  // stable through REPORT and leaves them readable in IDLE.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_tog_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_win_cnt <= '0;
      r_err_cnt <= '0;
      r_tog_cnt <= '0;
    end else if (w_start_run) begin
      r_win_cnt <= '0;
      r_err_cnt <= '0;
      r_tog_cnt <= '0;
    end else if (w_busy) begin
      r_win_cnt <= r_win_cnt + c_WIN_W'(1);
      if (w_violation) begin
        r_err_cnt <= CNT_W'(sat_inc(32'(r_err_cnt), CNT_W));
      end
      if (w_toggle) begin
        r_tog_cnt <= CNT_W'(sat_inc(32'(r_tog_cnt), CNT_W));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.busy      = w_busy;
  assign bus.res_valid = w_res_valid;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.tog_cnt   = r_tog_cnt;
  assign bus.pass      = (r_err_cnt == '0);

endmodule : comb_loop_checker
`default_nettype wire

// File: tb/tb_comb_loop_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_comb_loop_checker
// Brief    : Self-checking bench for comb_loop_checker. Two instances run in
//            lock-step on shared stimulus: CNT_W=8 and CNT_W=3 (saturation),
//            both WINDOW=16. Expected results come from a history of the
//            inputs seen at each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comb_loop_checker;

  localparam int WINDOW = 16;
  localparam int CNT_W  = 8;
  localparam int SAT_W  = 3;

  logic sys_clk;
  logic sys_rst_n;

  comb_loop_checker_if #(.CNT_W(CNT_W)) bus ();
  comb_loop_checker_if #(.CNT_W(SAT_W)) bus_sat ();

  assign bus_sat.start     = bus.start;
  assign bus_sat.a_in      = bus.a_in;
  assign bus_sat.b_in      = bus.b_in;
  assign bus_sat.c_in      = bus.c_in;
  assign bus_sat.res_ready = bus.res_ready;

  comb_loop_checker #(.WINDOW(WINDOW), .CNT_W(CNT_W)) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  comb_loop_checker #(.WINDOW(WINDOW), .CNT_W(SAT_W)) u_dut_sat (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_sat)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Input values as seen at every rising edge. While reset is low the
  // synchronizers are cleared, so zeros are recorded.
  bit qa[$];
  bit qb[$];
  bit qc[$];

  always @(posedge sys_clk) begin
    if (sys_rst_n) begin
      qa.push_back(bus.a_in);
      qb.push_back(bus.b_in);
      qc.push_back(bus.c_in);
    end else begin
      qa.push_back(1'b0);
      qb.push_back(1'b0);
      qc.push_back(1'b0);
    end
  end

  function automatic bit hv(input int which, input int idx);
    if (idx < 0) return 1'b0;
    case (which)
      0:       return qa[idx];
      1:       return qb[idx];
      default: return qc[idx];
    endcase
  endfunction

  // A run started at edge s checks edges s+1..s+WINDOW. Each check sees the
  // inputs from two edges earlier. The toggle check also looks one edge
  // further back.
  task automatic model(input int s, input int cntw, output int err, output int tog);
    int max_v;
    bit a, b, c, cp;
    max_v = (1 << cntw) - 1;
    err   = 0;
    tog   = 0;
    for (int k = s + 1; k <= s + WINDOW; k++) begin
      a  = hv(0, k - 2);
      b  = hv(1, k - 2);
      c  = hv(2, k - 2);
      cp = hv(2, k - 3);
      if (b != c || c == a) err++;
      if (c != cp) tog++;
    end
    if (err > max_v) err = max_v;
    if (tog > max_v) tog = max_v;
  endtask

  // Modes: 0 consistent, 1 broken (b!=c), 2 c toggling every 2 cycles,
  // 3 random with bias toward consistent cycles.
  task automatic drive(input int mode);
    int k;
    bit c_v;
    k = qa.size();
    case (mode)
      0: begin bus.a_in = 1'b1; bus.b_in = 1'b0; bus.c_in = 1'b0; end
      1: begin bus.a_in = 1'b1; bus.b_in = 1'b1; bus.c_in = 1'b0; end
      2: begin
        c_v = ((k / 2) % 2) != 0;
        bus.c_in = c_v; bus.b_in = c_v; bus.a_in = ~c_v;
      end
      default: begin
        c_v = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          bus.c_in = c_v; bus.b_in = c_v; bus.a_in = ~c_v;
        end else begin
          bus.c_in = c_v;
          bus.b_in = 1'($urandom_range(0, 1));
          bus.a_in = 1'($urandom_range(0, 1));
        end
      end
    endcase
  endtask

  // Pre-fills the synchronizers, pulses start and runs until res_valid is
  // seen or the cycle budget expires (lat stays -1). It returns at the first
  // negedge where res_valid is high.
  task automatic run_window(input int mode, input bit early_ready, input bit poke_start,
                            output int s, output int busy_n, output int lat);
    bus.res_ready = early_ready;
    repeat (4) begin
      @(negedge sys_clk);
      drive(mode);
    end
    @(negedge sys_clk);
    drive(mode);
    s = qa.size();
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    busy_n = 0;
    lat    = -1;
    for (int i = 1; i <= WINDOW + 20; i++) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.res_valid === 1'b1) begin
        lat = i - 1;
        break;
      end
      bus.start = poke_start && (i == 5);
      drive(mode);
      @(negedge sys_clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b expected=0", bus.busy); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid actual=%b expected=0", bus.res_valid); end
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL reset_pass actual=%b expected=1", bus.pass); end
    checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt actual=%0d expected=0", bus.err_cnt); end
    checks++; if (bus.tog_cnt !== 8'd0) begin errors++; $display("FAIL reset_tog_cnt actual=%0d expected=0", bus.tog_cnt); end
    checks++; if (bus_sat.err_cnt !== 3'd0) begin errors++; $display("FAIL reset_sat_err_cnt actual=%0d expected=0", bus_sat.err_cnt); end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle busy=%b res_valid=%b expected=0/0", bus.busy, bus.res_valid);
    end
  endtask

  task automatic test_consistent();
    int s, bn, lat, e, t, e3, t3;
    run_window(0, 1'b0, 1'b0, s, bn, lat);
    model(s, CNT_W, e, t);
    model(s, SAT_W, e3, t3);
    checks++; if (lat != WINDOW) begin errors++; $display("FAIL cons_latency actual=%0d expected=%0d", lat, WINDOW); end
    checks++; if (bn != WINDOW) begin errors++; $display("FAIL cons_busy_cycles actual=%0d expected=%0d", bn, WINDOW); end
    checks++; if (bus.err_cnt !== 8'(e)) begin errors++; $display("FAIL cons_err_cnt actual=%0d expected=%0d", bus.err_cnt, e); end
    checks++; if (bus.tog_cnt !== 8'(t)) begin errors++; $display("FAIL cons_tog_cnt actual=%0d expected=%0d", bus.tog_cnt, t); end
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL cons_pass actual=%b expected=1", bus.pass); end
    bus.res_ready = 1'b1;
    @(negedge sys_clk);
    bus.res_ready = 1'b0;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL cons_valid_drop actual=%b expected=0", bus.res_valid); end
    repeat (3) @(negedge sys_clk);
    checks++; if (bus.err_cnt !== 8'(e) || bus.busy !== 1'b0) begin
      errors++; $display("FAIL cons_idle_hold err_cnt=%0d busy=%b expected=%0d/0", bus.err_cnt, bus.busy, e);
    end
  endtask

  task automatic test_broken();
    int s, bn, lat, e, t, e3, t3;
    run_window(1, 1'b0, 1'b0, s, bn, lat);
    model(s, CNT_W, e, t);
    model(s, SAT_W, e3, t3);
    checks++; if (lat != WINDOW) begin errors++; $display("FAIL brk_latency actual=%0d expected=%0d", lat, WINDOW); end
    checks++; if (bus.err_cnt !== 8'(e)) begin errors++; $display("FAIL brk_err_cnt actual=%0d expected=%0d", bus.err_cnt, e); end
    checks++; if (bus.pass !== (e == 0)) begin errors++; $display("FAIL brk_pass actual=%b expected=%b", bus.pass, (e == 0)); end
    checks++; if (bus_sat.err_cnt !== 3'(e3)) begin errors++; $display("FAIL sat_err_cnt actual=%0d expected=%0d", bus_sat.err_cnt, e3); end
    checks++; if (bus_sat.pass !== (e3 == 0)) begin errors++; $display("FAIL sat_pass actual=%b expected=%b", bus_sat.pass, (e3 == 0)); end
    bus.res_ready = 1'b1;
    @(negedge sys_clk);
    bus.res_ready = 1'b0;
    checks++; if (bus_sat.res_valid !== 1'b0) begin errors++; $display("FAIL brk_valid_drop actual=%b expected=0", bus_sat.res_valid); end
  endtask

  task automatic test_toggle();
    int s, bn, lat, e, t, e3, t3;
    run_window(2, 1'b0, 1'b0, s, bn, lat);
    model(s, CNT_W, e, t);
    model(s, SAT_W, e3, t3);
    checks++; if (bus.tog_cnt !== 8'(t)) begin errors++; $display("FAIL tog_tog_cnt actual=%0d expected=%0d", bus.tog_cnt, t); end
    checks++; if (bus.err_cnt !== 8'(e)) begin errors++; $display("FAIL tog_err_cnt actual=%0d expected=%0d", bus.err_cnt, e); end
    checks++; if (bus_sat.tog_cnt !== 3'(t3)) begin errors++; $display("FAIL sat_tog_cnt actual=%0d expected=%0d", bus_sat.tog_cnt, t3); end
    bus.res_ready = 1'b1;
    @(negedge sys_clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int s, bn, lat, e, t, e3, t3;
    run_window(3, 1'b0, 1'b0, s, bn, lat);
    model(s, CNT_W, e, t);
    model(s, SAT_W, e3, t3);
    for (int i = 0; i < 10; i++) begin
      bus.start = (i % 2) == 0;
      drive(3);
      @(negedge sys_clk);
      checks++; if (bus.res_valid !== 1'b1 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL bp_state cyc=%0d res_valid=%b busy=%b expected=1/0", i, bus.res_valid, bus.busy);
      end
      checks++; if (bus.err_cnt !== 8'(e) || bus.tog_cnt !== 8'(t) || bus.pass !== (e == 0)) begin
        errors++; $display("FAIL bp_hold cyc=%0d err=%0d tog=%0d pass=%b expected=%0d/%0d/%b",
                           i, bus.err_cnt, bus.tog_cnt, bus.pass, e, t, (e == 0));
      end
      checks++; if (bus_sat.err_cnt !== 3'(e3)) begin
        errors++; $display("FAIL bp_sat_hold cyc=%0d err=%0d expected=%0d", i, bus_sat.err_cnt, e3);
      end
    end
    // start coinciding with the handshake edge must not launch a run
    bus.start     = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge sys_clk);
    bus.start     = 1'b0;
    bus.res_ready = 1'b0;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop actual=%b expected=0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored busy=%b expected=0", bus.busy); end
    @(negedge sys_clk);
    checks++; if (bus.busy !== 1'b0 || bus.err_cnt !== 8'(e)) begin
      errors++; $display("FAIL bp_idle busy=%b err=%0d expected=0/%0d", bus.busy, bus.err_cnt, e);
    end
  endtask

  task automatic test_random();
    int s, bn, lat, e, t, e3, t3;
    bit early;
    for (int r = 0; r < 6; r++) begin
      early = (r % 2) == 1;
      run_window(3, early, (r == 2), s, bn, lat);
      model(s, CNT_W, e, t);
      model(s, SAT_W, e3, t3);
      checks++; if (lat != WINDOW || bn != WINDOW) begin
        errors++; $display("FAIL rnd_timing run=%0d lat=%0d busy=%0d expected=%0d/%0d", r, lat, bn, WINDOW, WINDOW);
      end
      checks++; if (bus.err_cnt !== 8'(e)) begin errors++; $display("FAIL rnd_err_cnt run=%0d actual=%0d expected=%0d", r, bus.err_cnt, e); end
      checks++; if (bus.tog_cnt !== 8'(t)) begin errors++; $display("FAIL rnd_tog_cnt run=%0d actual=%0d expected=%0d", r, bus.tog_cnt, t); end
      checks++; if (bus.pass !== (e == 0)) begin errors++; $display("FAIL rnd_pass run=%0d actual=%b expected=%b", r, bus.pass, (e == 0)); end
      checks++; if (bus_sat.err_cnt !== 3'(e3) || bus_sat.tog_cnt !== 3'(t3)) begin
        errors++; $display("FAIL rnd_sat run=%0d err=%0d tog=%0d expected=%0d/%0d", r, bus_sat.err_cnt, bus_sat.tog_cnt, e3, t3);
      end
      bus.res_ready = 1'b1;
      @(negedge sys_clk);
      bus.res_ready = 1'b0;
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rnd_valid_drop run=%0d actual=%b expected=0", r, bus.res_valid); end
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_valid, seen_busy;
    repeat (4) begin
      @(negedge sys_clk);
      drive(1);
    end
    @(negedge sys_clk);
    bus.start = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    repeat (5) @(negedge sys_clk);
    checks++; if (bus.busy !== 1'b1 || bus.err_cnt === 8'd0) begin
      errors++; $display("FAIL mid_pre_reset busy=%b err=%0d expected=1/nonzero", bus.busy, bus.err_cnt);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy actual=%b expected=0", bus.busy); end
    checks++; if (bus.err_cnt !== 8'd0 || bus.tog_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_counters err=%0d tog=%0d expected=0/0", bus.err_cnt, bus.tog_cnt);
    end
    checks++; if (bus.pass !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++; $display("FAIL mid_outputs pass=%b res_valid=%b expected=1/0", bus.pass, bus.res_valid);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    seen_valid = 0;
    seen_busy  = 0;
    for (int i = 0; i < 2 * WINDOW + 8; i++) begin
      @(negedge sys_clk);
      if (bus.res_valid !== 1'b0) seen_valid++;
      if (bus.busy !== 1'b0) seen_busy++;
    end
    checks++; if (seen_valid != 0 || seen_busy != 0) begin
      errors++; $display("FAIL mid_no_result valid_cycles=%0d busy_cycles=%0d expected=0/0", seen_valid, seen_busy);
    end
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    bus.start     = 1'b0;
    bus.a_in      = 1'b0;
    bus.b_in      = 1'b0;
    bus.c_in      = 1'b0;
    bus.res_ready = 1'b0;
    test_reset();
    test_consistent();
    test_broken();
    test_toggle();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_comb_loop_checker
`default_nettype wire

// File: doc/comb_loop_checker.md
COMB_LOOP_CHECKER -- requirements
Module: comb_loop_checker

Interface
REQ-001 The module SHALL have parameter WINDOW, default 16, giving the number of checked cycles per run (legal range 1..65535).
REQ-002 The module SHALL have parameter CNT_W, default 8, giving the width of the result counters.
REQ-003 Port sys_clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port sys_rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port start  input  1  is a one-cycle request to begin a check run.
REQ-006 Port a_in, b_in, c_in  input  1 each  are the upstream comb-loop outputs a, b, c, asynchronous to sys_clk.
REQ-007 Port busy  output  1  SHALL be high while in RUN.
REQ-008 Port res_valid  output  1  SHALL indicate that the result is presented.
REQ-009 Port res_ready  input  1  SHALL be the consumer's acceptance of the result.
REQ-010 Port err_cnt  output  CNT_W  is the count of invariant violations in the last run.
REQ-011 Port tog_cnt  output  CNT_W  is the count of c transitions in the last run.
REQ-012 Port pass  output  1  SHALL be high when err_cnt is zero; it is meaningful only while res_valid is high.

Function
REQ-013 Each of a_in, b_in, c_in SHALL pass through a 2-flop synchronizer; the synchronized values are a_s, b_s, c_s, with 2 cycles of latency.
REQ-014 A register c_prev SHALL capture c_s every cycle in every state.
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and REPORT.
REQ-016 IDLE -> RUN SHALL occur when start=1; on that edge the window counter, err_cnt and tog_cnt SHALL clear to 0.
REQ-017 In RUN, a cycle SHALL be a violation when (b_s != c_s) or (c_s == a_s); err_cnt SHALL increment by 1 per violation cycle.
REQ-018 In RUN, tog_cnt SHALL increment by 1 when c_s != c_prev.
REQ-019 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 RUN SHALL last exactly WINDOW cycles; after the WINDOW-th checked cycle the FSM SHALL enter REPORT.
REQ-021 In REPORT, res_valid SHALL be 1, and err_cnt, tog_cnt and pass SHALL be held stable until the handshake completes.
REQ-022 REPORT -> IDLE SHALL occur on the edge where res_valid=1 and res_ready=1; res_valid SHALL drop in the following cycle.
REQ-023 res_ready may be high before res_valid; the handshake SHALL then complete in the first REPORT cycle.
REQ-024 start SHALL be ignored in RUN and in REPORT, with no restart and no counter clear.
REQ-025 start asserted in the same cycle as the REPORT->IDLE transition SHALL be ignored; a new start is accepted only from IDLE.
REQ-026 Counters SHALL retain their last values in IDLE until the next start.

Reset
REQ-027 On sys_rst_n=0 the module SHALL immediately force state to IDLE and clear the synchronizers, c_prev, the window counter, err_cnt and tog_cnt to 0.
REQ-028 During reset, busy and res_valid SHALL be 0 and pass SHALL be 1.
REQ-029 Reset asserted mid-RUN or mid-REPORT SHALL discard the run; no result SHALL be presented after release.
REQ-030 Reset release SHALL be handled synchronously to sys_clk by the integrator; no internal release synchronizer is required.

Structure
REQ-031 The FSM state encoding and the saturating-increment width rule SHALL live in a shared package, comb_loop_pkg.
REQ-032 The 2-flop synchronizer SHALL be a sub-module, sync_2ff, instantiated three times.
REQ-033 The window counter width SHALL be derived from WINDOW as clog2(WINDOW+1).

Verification
REQ-034 Consistent inputs: hold a=1, b=0, c=0, start, WINDOW=16 -> res_valid after 16 RUN cycles, err_cnt=0, tog_cnt=0, pass=1.
REQ-035 Broken loop: hold a=1, b=1, c=0 through the run -> err_cnt=16, pass=0.
REQ-036 Toggling: drive a/c consistently with c toggling every 2 cycles over 16 cycles -> tog_cnt=8, err_cnt=0 (sync latency accounted for).
REQ-037 Saturation: CNT_W=3, WINDOW=16, constant violation -> err_cnt=7, with no wrap.
REQ-038 Backpressure and start: hold res_ready=0 for 10 cycles in REPORT while pulsing start -> outputs stable, state stays REPORT; then res_ready=1 -> IDLE next cycle.
REQ-039 Reset mid-RUN: assert sys_rst_n=0 at RUN cycle 5 -> busy=0 and counters 0 immediately; no res_valid after release without a new start.
